// File: rtl/imem_read_arbiter.sv
// Two-requester arbiter for the instruction memory's single combinational read port.
// Fetch has priority; a starvation counter forces one debug slot after STARVE_MAX denials.
module imem_read_arbiter #(
    parameter int inputAbits = 32,
    parameter int Abits      = 9,
    parameter int Dbits      = 32,
    parameter int Cbits      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [inputAbits-1:0] cpu_addr,
    output logic                  cpu_stall,
    output logic                  cpu_valid,
    output logic [Dbits-1:0]      cpu_data,
    input  logic                  dbg_req,
    input  logic [inputAbits-1:0] dbg_addr,
    output logic                  dbg_valid,
    output logic [Dbits-1:0]      dbg_data,
    output logic                  dbg_err,
    output logic [inputAbits-1:0] mem_addr,
    input  logic [Dbits-1:0]      mem_dout
);

    localparam logic [Cbits-1:0] STARVE_LIM = Cbits'(STARVE_MAX);

    logic [Cbits-1:0] starve_cnt;
    logic [Cbits-1:0] starve_nxt;
    logic             force_slot;
    logic             cpu_gnt;
    logic             dbg_gnt;

    function automatic logic [Cbits-1:0] sat_inc(input logic [Cbits-1:0] c);
        return (c == STARVE_LIM) ? c : c + Cbits'(1);
    endfunction

    // Address bits beyond the implemented memory alias onto low words.
    function automatic logic addr_oob(input logic [inputAbits-1:0] a);
        return (a >> Abits) != '0;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) starve_cnt <= '0;
        else       starve_cnt <= starve_nxt;
    end

    always_comb begin
        starve_nxt = '0;
        if (dbg_req && !dbg_gnt)
            starve_nxt = sat_inc(starve_cnt);
    end

    // dbg_valid doubles as the busy flag, so debug can win at most every other cycle.
    always_comb begin
        force_slot = dbg_req & (starve_cnt == STARVE_LIM);
        dbg_gnt    = ~reset & dbg_req & ~dbg_valid & (force_slot | ~cpu_req);
        cpu_gnt    = ~reset & cpu_req & ~dbg_gnt;
        cpu_stall  = cpu_req & ~cpu_gnt;
        mem_addr   = '0;
        if (cpu_gnt)      mem_addr = cpu_addr;
        else if (dbg_gnt) mem_addr = dbg_addr;
    end

    // Response stage: memory read data captured one cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_valid <= 1'b0;
            cpu_data  <= '0;
            dbg_valid <= 1'b0;
            dbg_data  <= '0;
            dbg_err   <= 1'b0;
        end else begin
            cpu_valid <= cpu_gnt;
            dbg_valid <= dbg_gnt;
            dbg_err   <= dbg_gnt & addr_oob(dbg_addr);
            if (cpu_gnt) cpu_data <= mem_dout;
            if (dbg_gnt) dbg_data <= mem_dout;
        end
    end

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Scoreboard bench for imem_read_arbiter: directed cycles push expected responses,
// a negedge monitor pops and checks data and exact one-cycle latency.
module tb_imem_read_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_stall;
    logic        cpu_valid;
    logic [31:0] cpu_data;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        dbg_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;

    logic [31:0] mem [512];

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t cq[$];
    exp_t dq[$];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    imem_read_arbiter #(
        .inputAbits(32), .Abits(9), .Dbits(32), .Cbits(4), .STARVE_MAX(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_valid(dbg_valid),
        .dbg_data(dbg_data), .dbg_err(dbg_err),
        .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr[8:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid must match the oldest expectation, in exactly its due cycle.
    always @(negedge clk) begin
        if (cpu_valid === 1'b1) begin
            if (cq.size() == 0) chk("cpu_unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = cq.pop_front();
                chk("cpu_latency", cyc, e.due);
                chk("cpu_data", cpu_data, e.data);
            end
        end else if (cq.size() != 0 && cq[0].due <= cyc) begin
            chk("cpu_missing_valid", cpu_valid, 1);
            void'(cq.pop_front());
        end
        if (dbg_valid === 1'b1) begin
            if (dq.size() == 0) chk("dbg_unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = dq.pop_front();
                chk("dbg_latency", cyc, e.due);
                chk("dbg_data", dbg_data, e.data);
                chk("dbg_err", dbg_err, e.err);
            end
        end else if (dq.size() != 0 && dq[0].due <= cyc) begin
            chk("dbg_missing_valid", dbg_valid, 1);
            void'(dq.pop_front());
        end
    end

    // One cycle of stimulus with the grants expected for it.
    task automatic step(input logic rs, input logic cr, input logic [31:0] ca,
                        input logic dr, input logic [31:0] da,
                        input logic cg, input logic dg);
        logic [31:0] exp_addr;
        reset    = rs;
        cpu_req  = cr;
        cpu_addr = ca;
        dbg_req  = dr;
        dbg_addr = da;
        exp_addr = cg ? ca : (dg ? da : 32'h0);
        @(negedge clk);
        chk("cpu_stall", cpu_stall, cr & ~cg);
        chk("mem_addr", mem_addr, exp_addr);
        if (cg) cq.push_back('{cyc + 1, 1'b0, mem[ca[8:0]]});
        if (dg) dq.push_back('{cyc + 1, (da[31:9] != 0), mem[da[8:0]]});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    // Fetch and debug both requesting: eight fetch wins, forced debug, then fetch resumes.
    task automatic starve_run(input logic [31:0] base, input logic [31:0] da);
        for (int i = 0; i < 8; i++) step(0, 1, base + 32'(4 * i), 1, da, 1, 0);
        step(0, 1, base + 32'd32, 1, da, 0, 1);
        step(0, 1, base + 32'd32, 1, da, 1, 0);
        step(0, 1, base + 32'd36, 0, 32'h0, 1, 0);
        idle();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + 32'(i * 3);
        reset = 1; cpu_req = 0; cpu_addr = 0; dbg_req = 0; dbg_addr = 0;
        @(posedge clk);
        #1;

        // Reset: requests ignored, outputs at reset values
        step(1, 1, 32'h4, 1, 32'h8, 0, 0);
        step(1, 1, 32'h4, 0, 32'h0, 0, 0);
        chk("rst_cpu_data", cpu_data, 0);
        chk("rst_dbg_data", dbg_data, 0);
        chk("rst_dbg_err", dbg_err, 0);

        // Fetch only, back to back
        step(0, 1, 32'h0, 0, 32'h0, 1, 0);
        step(0, 1, 32'h4, 0, 32'h0, 1, 0);
        step(0, 1, 32'h8, 0, 32'h0, 1, 0);
        idle();
        idle();
        chk("cpu_data_hold", cpu_data, mem[8]);

        // Debug in idle slot, no re-grant while busy
        step(0, 0, 32'h0, 1, 32'h1F, 0, 1);
        step(0, 0, 32'h0, 1, 32'h1F, 0, 0);
        idle();
        chk("dbg_data_hold", dbg_data, mem[31]);

        // Starvation forces debug on the ninth contended cycle
        starve_run(32'h40, 32'h40);

        // Out-of-range debug address aliases to word 0 and flags an error
        step(0, 0, 32'h0, 1, 32'h0000_0200, 0, 1);
        idle();
        idle();
        chk("dbg_err_clear", dbg_err, 0);

        // Reset right after a fetch grant
        step(0, 1, 32'h10, 0, 32'h0, 1, 0);
        step(1, 1, 32'h14, 1, 32'h8, 0, 0);
        chk("rst_mid_cpu_valid", cpu_valid, 0);
        chk("rst_mid_cpu_data", cpu_data, 0);
        step(1, 1, 32'h14, 1, 32'h8, 0, 0);
        chk("rst_mid_dbg_data", dbg_data, 0);
        chk("rst_mid_dbg_valid", dbg_valid, 0);
        // Counter must restart from zero: full eight fetch wins before forced debug
        starve_run(32'h80, 32'h8);

        // Simultaneous arrival; debug wins once fetch drops after three cycles
        step(0, 1, 32'h100, 1, 32'h33, 1, 0);
        step(0, 1, 32'h104, 1, 32'h33, 1, 0);
        step(0, 1, 32'h108, 1, 32'h33, 1, 0);
        step(0, 0, 32'h0, 1, 32'h33, 0, 1);
        idle();
        idle();

        chk("cpu_queue_drained", cq.size(), 0);
        chk("dbg_queue_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_read_arbiter.md
Name: imem_read_arbiter

Overview:
- Shares the single combinational read port of the instruction memory between two requesters: processor fetch (port C) and a debug/readback requester (port D), e.g. a UART monitor dumping program memory.
- Fixed priority to fetch, with a starvation counter that forces one debug slot after STARVE_MAX consecutive denied cycles.
- Responses are registered, with 1-cycle latency; a stall output freezes the processor PC when fetch is denied.
- Sits between the processor fetch stage and the instruction memory.

Parameters:
inputAbits, 32, width of requester and memory-port addresses
Abits, 9, implemented memory address bits; higher address bits must be zero
Dbits, 32, data width
Cbits, 4, starvation counter width
STARVE_MAX, 8, denied debug cycles before a forced debug grant; 1 <= STARVE_MAX <= 2**Cbits-1

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
cpu_req  in  1  fetch request this cycle
cpu_addr  in  inputAbits  fetch byte/word address as issued by processor
cpu_stall  out  1  combinational: cpu_req & ~cpu_gnt; processor holds PC/addr while high
cpu_valid  out  1  registered: fetch data valid this cycle
cpu_data  out  Dbits  registered fetch data
dbg_req  in  1  debug request; held with stable dbg_addr until dbg_valid
dbg_addr  in  inputAbits  debug read address
dbg_valid  out  1  registered: one-cycle pulse, debug data valid
dbg_data  out  Dbits  registered debug data
dbg_err  out  1  registered with dbg_valid: granted dbg_addr had nonzero bits [inputAbits-1:Abits]
mem_addr  out  inputAbits  to memory addr; combinational mux of granted address, 0 when no grant
mem_dout  in  Dbits  from memory dout (combinational read)

Behaviour:
- Grant (combinational, same cycle):
  - force = dbg_req & (starve_cnt == STARVE_MAX).
  - dbg_gnt = ~reset & dbg_req & (force | ~cpu_req).
  - cpu_gnt = ~reset & cpu_req & ~dbg_gnt.
  - At most one grant per cycle.
- mem_addr = cpu_addr if cpu_gnt, dbg_addr if dbg_gnt, else 0. Passed at full width; the memory truncates.
- Response capture at the next edge:
  - cpu_valid <= cpu_gnt; cpu_data <= mem_dout when cpu_gnt, else holds.
  - dbg_valid <= dbg_gnt; dbg_data <= mem_dout when dbg_gnt, else holds.
  - dbg_err <= dbg_gnt & (dbg_addr[inputAbits-1:Abits] != 0), else 0. Data is still returned when dbg_err is set (aliased word).
- Latency: exactly 1 cycle, grant to valid. Back-to-back fetch grants give valid every cycle (throughput 1/cycle).
- Starvation counter starve_cnt (Cbits):
  - 0 on reset.
  - 0 on any cycle with dbg_gnt or ~dbg_req.
  - Increments when dbg_req & ~dbg_gnt; saturates at STARVE_MAX.
  - Forced grant occurs on the cycle the counter equals STARVE_MAX, so debug waits at most STARVE_MAX denied cycles.
- Debug handshake:
  - Requester must keep dbg_req/dbg_addr stable until dbg_valid.
  - In the cycle after dbg_gnt, the requester may drop dbg_req or present a new address; new requests are considered starting in that cycle.
  - The arbiter itself blocks dbg re-grant in the cycle dbg_valid is high, by registered dbg_gnt (dbg_busy = dbg_valid). Max debug rate is 1 per 2 cycles.
- State: CPU-priority mode (starve_cnt < STARVE_MAX) and FORCE mode (starve_cnt == STARVE_MAX & dbg_req).
  - FORCE lasts exactly one cycle, then returns to CPU-priority with counter 0.
  - In the FORCE cycle, cpu_stall = cpu_req.
- Simultaneous cpu_req & dbg_req with counter below STARVE_MAX: CPU wins; debug counter increments.
- Reset (asserted at any time, including a cycle after grant):
  - Pending responses are dropped.
  - Registered outputs take their reset values on that edge: cpu_valid=0, cpu_data=0, dbg_valid=0, dbg_data=0, dbg_err=0, starve_cnt=0.
  - While reset is high: no grants, mem_addr=0, cpu_stall=cpu_req.
- No requests: mem_addr=0, valids 0, data outputs hold last values.

Test Plan:
1. Fetch only: reset 2 cycles, then cpu_req=1 with cpu_addr=0,4,8 on successive cycles, memory preloaded → cpu_valid=1 on following cycles with cpu_data=mem[0],mem[4],mem[8]; cpu_stall=0 throughout.
2. Debug idle slot: cpu_req=0, dbg_req=1, dbg_addr=0x1F → mem_addr=0x1F same cycle; next cycle dbg_valid=1, dbg_data=mem[0x1F], dbg_err=0; dbg_valid not reasserted the following cycle even with dbg_req still high.
3. Starvation, STARVE_MAX=8: cpu_req=1 continuously, dbg_req=1 from cycle 0 → cycles 0–7 cpu_gnt, cpu_stall=0; cycle 8 dbg_gnt, cpu_stall=1; cycle 9 dbg_valid=1 and cpu_gnt resumes with starve_cnt=0.
4. Out-of-range debug: dbg_addr=0x0000_0200 with Abits=9 → dbg_valid=1, dbg_err=1, dbg_data=mem[0].
5. Reset mid-operation: cpu_gnt in cycle N, reset=1 in cycle N+1 → cpu_valid=0, cpu_data=0 after the edge; no grants and mem_addr=0 while reset is high; starve_cnt=0 after deassert.
6. Simultaneous arrival: cpu_req and dbg_req rise together, cpu_req drops after 3 cycles → dbg granted in cycle 3 (counter=3, below max); dbg_valid in cycle 4; counter cleared.
